// File: rtl/mips_mem_pkg.sv
// Shared types, widths and address-check helper for the MIPS data-memory responder.
// Nothing in this package changes when DMEM_BYTE_EN is defined.
package mips_mem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int LAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Misaligned word access, or address bits set above the word array.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_bits);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_bits + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Request/response valid-ready bus between the MIPS core and its data-memory responder.
// req_be is only present when DMEM_BYTE_EN is defined.
interface mips_dmem_responder_if;
  import mips_mem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [DMEM_WORD_W-1:0] req_addr;
  logic [DMEM_WORD_W-1:0] req_wdata;
`ifdef DMEM_BYTE_EN
  logic [3:0]             req_be;
`endif
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DMEM_WORD_W-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_BYTE_EN
    output req_be,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_BYTE_EN
    input  req_be,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mips_dmem_array.sv
// Synchronous 1R/1W word array with per-byte write lanes; contents are never reset.
// Lane strobes are always wired; the top ties them high unless DMEM_BYTE_EN is defined.
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                   CLK,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_idx,
  input  logic [DMEM_WORD_W-1:0] wr_data,
  input  logic [3:0]             wr_be,
  input  logic                   rd_en,
  input  logic [ADDR_BITS-1:0]   rd_idx,
  output logic [DMEM_WORD_W-1:0] rd_data
);

  logic [DMEM_WORD_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles, then holds a response until consumed.
// Define DMEM_BYTE_EN to enable per-byte store strobes on req_be.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int LATENCY   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  mips_dmem_responder_if.slave bus
);

  dmem_state_t            state;
  dmem_state_t            state_nxt;
  logic [LAT_CNT_W-1:0]   cnt;
  logic                   enter_resp;
  logic                   accept;

  logic                   lat_write;
  logic [DMEM_WORD_W-1:0] lat_addr;
  logic [DMEM_WORD_W-1:0] lat_wdata;
  logic                   lat_err;

  logic                   cur_write;
  logic [DMEM_WORD_W-1:0] cur_addr;
  logic [DMEM_WORD_W-1:0] cur_wdata;
  logic [3:0]             cur_be;
  logic                   cur_err;
  logic [DMEM_WORD_W-1:0] arr_rdata;

  assign accept = bus.req_valid & bus.req_ready;

  // With zero latency the array is accessed on the acceptance edge, before the latch holds the request.
  assign cur_write = (state == IDLE) ? bus.req_write : lat_write;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

`ifdef DMEM_BYTE_EN
  logic [3:0] lat_be;

  always_ff @(posedge CLK) begin
    if (RST)         lat_be <= 4'h0;
    else if (accept) lat_be <= bus.req_be;
  end

  assign cur_be  = (state == IDLE) ? bus.req_be : lat_be;
  assign cur_err = addr_err(cur_addr, ADDR_BITS) | (cur_write & (cur_be == 4'h0));
  assign lat_err = addr_err(lat_addr, ADDR_BITS) | (lat_write & (lat_be == 4'h0));
`else
  assign cur_be  = 4'hF;
  assign cur_err = addr_err(cur_addr, ADDR_BITS);
  assign lat_err = addr_err(lat_addr, ADDR_BITS);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= LAT_CNT_W'(LATENCY);
      else if (state == WAIT)  cnt <= cnt - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAT_CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset on the commit edge must drop the store, not just the response.
  mips_dmem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .CLK     (CLK),
    .wr_en   (enter_resp & cur_write & ~cur_err & ~RST),
    .wr_idx  (cur_addr[ADDR_BITS+1:2]),
    .wr_data (cur_wdata),
    .wr_be   (cur_be),
    .rd_en   (enter_resp & ~cur_write),
    .rd_idx  (cur_addr[ADDR_BITS+1:2]),
    .rd_data (arr_rdata)
  );

  assign bus.req_ready = (state == IDLE) & ~RST;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) & lat_err;
  assign bus.rsp_rdata = ((state == RESP) && !lat_write && !lat_err) ? arr_rdata : '0;

endmodule
